// File: rtl/r2w_pkg.sv
// r2w_pkg: shared pointer type and Gray/binary/popcount helpers for r2w_ptr_sync_status.
// Helpers work on zero-extended 32-bit values. Zero extension does not change the
// Gray decode, the Gray encode or the popcount, so any pointer width up to 32 can use them.
package r2w_pkg;
    localparam int ADDRSIZE = 4;
    typedef logic [ADDRSIZE:0] ptr_t;

    function automatic logic [31:0] gray2bin(logic [31:0] g);
        logic [31:0] b;
        for (int i = 0; i < 32; i++) b[i] = ^(g >> i);
        return b;
    endfunction

    function automatic logic [31:0] bin2gray(logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic int popcount(logic [31:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 32; i++) n += int'(v[i]);
        return n;
    endfunction
endpackage

// File: rtl/r2w_ptr_sync_status_sync_chain.sv
// sync_chain: multi-flop synchroniser, kept as its own module so timing constraints can target it.
// Ports: wclk (clock), rst (async active-low reset), d (async input), q (last stage).
module sync_chain #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             wclk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] r_stage [STAGES];

    always_ff @(posedge wclk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < STAGES; i++) r_stage[i] <= '0;
        end else begin
            r_stage[0] <= d;
            for (int i = 1; i < STAGES; i++) r_stage[i] <= r_stage[i-1];
        end
    end

    assign q = r_stage[STAGES-1];
endmodule

// File: rtl/r2w_ptr_sync_status.sv
// r2w_ptr_sync_status: synchronises the read Gray pointer into wclk and derives fill level and flags.
// Ports: wclk, rst (async active-low), graycode_rptr (read-domain Gray pointer), wptr_bin (local
// write pointer), rptr_sync_gray, rptr_bin, fill_level, full, almost_full, rptr_adv, gray_err.
// Optional macro GRAY_CHECK_EN adds a sticky checker for multi-bit steps of the synchronised pointer.
module r2w_ptr_sync_status
    import r2w_pkg::*;
#(
    parameter int ADDRSIZE  = 4,
    parameter int STAGES    = 2,
    parameter int AF_THRESH = (1 << ADDRSIZE) - 2
) (
    input  logic              wclk,
    input  logic              rst,
    input  logic [ADDRSIZE:0] graycode_rptr,
    input  logic [ADDRSIZE:0] wptr_bin,
    output logic [ADDRSIZE:0] rptr_sync_gray,
    output logic [ADDRSIZE:0] rptr_bin,
    output logic [ADDRSIZE:0] fill_level,
    output logic              full,
    output logic              almost_full,
    output logic              rptr_adv,
    output logic              gray_err
);
    localparam int PW    = ADDRSIZE + 1;
    localparam int DEPTH = 1 << ADDRSIZE;

    if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
        $error("r2w_ptr_sync_status: STAGES must be 2..4");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_thresh
        $error("r2w_ptr_sync_status: AF_THRESH must be 1..DEPTH");
    end

    logic [ADDRSIZE:0] w_dec;
    logic [ADDRSIZE:0] w_level;

    sync_chain #(.WIDTH(PW), .STAGES(STAGES)) u_sync (
        .wclk (wclk),
        .rst  (rst),
        .d    (graycode_rptr),
        .q    (rptr_sync_gray)
    );

    // Level and flags use the pre-register decode so they stay coherent with rptr_bin.
    assign w_dec   = PW'(gray2bin(32'(rptr_sync_gray)));
    assign w_level = wptr_bin - w_dec;

    always_ff @(posedge wclk or negedge rst) begin
        if (!rst) begin
            rptr_bin    <= '0;
            fill_level  <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            rptr_adv    <= 1'b0;
        end else begin
            rptr_bin    <= w_dec;
            fill_level  <= w_level;
            // Illegal levels above DEPTH still report full rather than wrapping to not-full.
            full        <= 32'(w_level) >= DEPTH;
            almost_full <= 32'(w_level) >= AF_THRESH;
            rptr_adv    <= w_dec != rptr_bin;
        end
    end

`ifdef GRAY_CHECK_EN
    logic [ADDRSIZE:0] r_prev;
    logic              r_primed;

    // r_primed skips the first post-reset edge, where r_prev has no valid history yet.
    always_ff @(posedge wclk or negedge rst) begin
        if (!rst) begin
            r_prev   <= '0;
            r_primed <= 1'b0;
            gray_err <= 1'b0;
        end else begin
            r_prev   <= rptr_sync_gray;
            r_primed <= 1'b1;
            if (r_primed && popcount(32'(r_prev ^ rptr_sync_gray)) > 1) gray_err <= 1'b1;
        end
    end
`else
    assign gray_err = 1'b0;
`endif
endmodule

// File: tb/tb_r2w_ptr_sync_status.sv
// tb_r2w_ptr_sync_status: scoreboard bench for r2w_ptr_sync_status (ADDRSIZE=4, STAGES=2, AF_THRESH=14).
module tb_r2w_ptr_sync_status;
    localparam int AF = 14;

    logic       wclk = 1'b0;
    logic       rst  = 1'b1;
    logic [4:0] graycode_rptr = '0;
    logic [4:0] wptr_bin = '0;
    logic [4:0] rptr_sync_gray, rptr_bin, fill_level;
    logic       full, almost_full, rptr_adv, gray_err;

    r2w_ptr_sync_status #(.ADDRSIZE(4), .STAGES(2), .AF_THRESH(AF)) dut (
        .wclk           (wclk),
        .rst            (rst),
        .graycode_rptr  (graycode_rptr),
        .wptr_bin       (wptr_bin),
        .rptr_sync_gray (rptr_sync_gray),
        .rptr_bin       (rptr_bin),
        .fill_level     (fill_level),
        .full           (full),
        .almost_full    (almost_full),
        .rptr_adv       (rptr_adv),
        .gray_err       (gray_err)
    );

    always #5 wclk = ~wclk;

    typedef struct {
        logic [4:0] sync;
        logic [4:0] rbin;
        logic [4:0] lvl;
        logic       full;
        logic       af;
        logic       adv;
        logic       err;
    } exp_t;

    exp_t       sb[$];
    logic [4:0] gh[4];
    int         ecount;
    logic       err_m;
    int         n_chk = 0;
    int         n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    endtask

    function automatic logic [4:0] g2b(input logic [4:0] g);
        logic [4:0] b;
        b[4] = g[4];
        for (int i = 3; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    function automatic logic [4:0] b2g(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic int pop5(input logic [4:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 5; i++) if (v[i]) n++;
        return n;
    endfunction

    // Drive one cycle of stimulus, predict the post-edge outputs, then compare after the edge.
    task automatic step(input logic [4:0] g, input logic [4:0] w);
        exp_t e;
        graycode_rptr = g;
        wptr_bin = w;
        gh[3] = gh[2];
        gh[2] = gh[1];
        gh[1] = gh[0];
        gh[0] = g;
        ecount++;
        if (ecount >= 2 && pop5(gh[3] ^ gh[2]) > 1) err_m = 1'b1;
        e.sync = gh[1];
        e.rbin = g2b(gh[2]);
        e.lvl  = w - e.rbin;
        e.full = e.lvl >= 5'd16;
        e.af   = e.lvl >= 5'(AF);
        e.adv  = g2b(gh[2]) != g2b(gh[3]);
`ifdef GRAY_CHECK_EN
        e.err  = err_m;
`else
        e.err  = 1'b0;
`endif
        sb.push_back(e);
        @(posedge wclk);
        #1;
        e = sb.pop_front();
        check("sync", rptr_sync_gray, e.sync);
        check("rbin", rptr_bin, e.rbin);
        check("level", fill_level, e.lvl);
        check("full", full, e.full);
        check("afull", almost_full, e.af);
        check("adv", rptr_adv, e.adv);
        check("gerr", gray_err, e.err);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_sync"}, rptr_sync_gray, 0);
        check({tag, "_rbin"}, rptr_bin, 0);
        check({tag, "_level"}, fill_level, 0);
        check({tag, "_full"}, full, 0);
        check({tag, "_afull"}, almost_full, 0);
        check({tag, "_adv"}, rptr_adv, 0);
        check({tag, "_gerr"}, gray_err, 0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        #1;
        check_zero(tag);
        for (int i = 0; i < 4; i++) gh[i] = '0;
        ecount = 0;
        err_m = 1'b0;
        sb.delete();
    endtask

    task automatic release_reset();
        @(negedge wclk);
        rst = 1'b1;
    endtask

    initial begin
        graycode_rptr = 5'b10110;
        wptr_bin = 5'd7;
        #2;
        do_reset("rst0");
        repeat (3) @(posedge wclk);
        #1;
        check_zero("rst_hold");
        release_reset();
        repeat (3) step(5'b10110, 5'd7);
        check("tp1_rbin", rptr_bin, 27);
        check("tp1_level", fill_level, 12);

        for (int i = 0; i <= 32; i++) begin
            for (int r = 0; r < 4; r++) begin
                step(b2g(5'(i % 32)), 5'(i + 3));
                if (i == 20 && r == 1) begin
                    @(negedge wclk);
                    do_reset("rst_mid");
                    release_reset();
                end
            end
        end

        repeat (4) step(5'd0, 5'd0);
        repeat (5) step(5'd3, 5'd0);
`ifdef GRAY_CHECK_EN
        check("jump_gerr", gray_err, 1);
`else
        check("jump_gerr", gray_err, 0);
`endif

        @(negedge wclk);
        do_reset("rst2");
        release_reset();
        repeat (4) step(5'd0, 5'd16);
        check("full16", full, 1);
        check("afull16", almost_full, 1);
        repeat (3) step(b2g(5'd1), 5'd16);
        check("full15", full, 0);
        step(b2g(5'd1), 5'd14);
        check("af13", almost_full, 0);
        step(b2g(5'd1), 5'd15);
        check("af14", almost_full, 1);
        repeat (3) step(b2g(5'd19), 5'd3);
        check("wrap_level", fill_level, 16);
        check("wrap_full", full, 1);
        repeat (3) step(b2g(5'd3), 5'd3);
        check("empty_level", fill_level, 0);
        check("empty_full", full, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
